// File: rtl/fifo_pkg.sv
// Shared types and parameter checks for the FIFO stream reader.
package fifo_pkg;

    localparam int DATA_W_DEF = 8;

    typedef logic [1:0] occ_t;

    function automatic bit pkt_len_ok(input int n);
        return (n >= 1) && (n <= 256);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready output stream with packet framing.
interface fifo_stream_reader_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/fifo_stream_skid.sv
// Two-entry holding buffer: tail capture, head pop, wrapping 1-bit pointers.
module fifo_stream_skid
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd,
    output occ_t              occ,
    output logic [DATA_W-1:0] head_data
);

    logic [DATA_W-1:0] mem [2];
    logic              head;
    logic              tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            occ    <= '0;
        end else begin
            if (wr) begin
                mem[tail] <= wr_data;
                tail      <= ~tail;
            end
            if (rd) begin
                head <= ~head;
            end
            case ({wr, rd})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage is cleared on reset, so the idle head reads as zero.
    assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a 1-cycle-latency FIFO into a framed valid/ready stream.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PKT_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [DATA_W-1:0]    fifo_rd_data,
    fifo_stream_reader_if.master m,
    output logic [7:0]           beat_cnt
);

    localparam logic [7:0] LAST_BEAT = 8'(PKT_LEN - 1);

    if (!pkt_len_ok(PKT_LEN)) begin : g_bad_len
        $error("PKT_LEN must be within 1..256");
    end

    occ_t       occ;
    logic       inflight;
    logic       pop;
    logic [2:0] credit;

    assign m.m_valid = (occ != 2'd0);
    assign pop       = m.m_valid && m.m_ready;

    // Slots committed after this edge; the pop frees one this cycle.
    assign credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    assign fifo_rd_en = !rst && en && !fifo_empty && (credit <= 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= 8'd0;
        end else if (pop) begin
            beat_cnt <= (beat_cnt == LAST_BEAT) ? 8'd0 : beat_cnt + 8'd1;
        end
    end

    assign m.m_last = m.m_valid && (beat_cnt == LAST_BEAT);

    fifo_stream_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .wr        (inflight),
        .wr_data   (fifo_rd_data),
        .rd        (pop),
        .occ       (occ),
        .head_data (m.m_data)
    );

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side adapter for the team's synchronous byte FIFO. It pops words from the FIFO read port, which has one cycle of read latency, and presents them as a valid/ready stream with a 2-entry holding buffer, so a stalled consumer never loses data and an unstalled one gets one word per cycle. It also frames the stream into fixed-length packets with `m_last`. It sits between any FIFO instance and a downstream consumer, such as a serializer or packet engine.

## Interface
Parameters:
- `DATA_W`, default 8: word width; must match the FIFO data width.
- `PKT_LEN`, default 4: beats per packet; legal range 1..256.

Ports:
- `clk`, in, 1: clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: enables new FIFO reads; does not gate output delivery.
- `fifo_empty`, in, 1: FIFO empty flag.
- `fifo_rd_en`, out, 1: FIFO read strobe; combinational.
- `fifo_rd_data`, in, `DATA_W`: FIFO read data; valid in the cycle after an issued read.
- `m_valid`, out, 1: output word valid.
- `m_data`, out, `DATA_W`: output word.
- `m_last`, out, 1: final beat of a packet; qualified by `m_valid`.
- `m_ready`, in, 1: consumer accepts the word.
- `beat_cnt`, out, 8: index of the current beat within the packet.

## Operation
- State:
  - `occ`: buffer occupancy, 0..2.
  - `inflight`: 1 bit; a read was issued last cycle.
  - 2-entry buffer with head/tail pointers, 1 bit each, wrapping.
  - `beat_cnt`.
- Reset values:
  - `m_valid`=0, `m_data`=0, `m_last`=0, `beat_cnt`=0, `fifo_rd_en`=0.
  - `occ`=0, `inflight`=0, pointers=0.
- Output handshake:
  - `pop` = `m_valid && m_ready`.
  - `m_valid` = (`occ` != 0).
  - `m_data` is the head entry, driven from registered storage.
- Read issue:
  - `fifo_rd_en` = `!rst && en && !fifo_empty && (occ + inflight - pop) <= 1`.
  - This is a credit rule. The buffer can never overflow, and back-to-back reads sustain 1 word/cycle while `m_ready` is high.
- Capture: when `inflight`=1, `fifo_rd_data` is written at the tail, tail increments, and `occ` increments.
- Simultaneous capture and pop in the same cycle: `occ` is unchanged and both pointers advance.
- Stalls: when `m_ready`=0, `m_valid` and `m_data` hold stable until accepted. Once `occ`=2, no read is issued.
- `en` deasserted: no new reads. The in-flight word is still captured, and buffered words still drain.
- Framing:
  - `m_last` = `m_valid && (beat_cnt == PKT_LEN-1)`.
  - On `pop`, `beat_cnt` increments, or wraps to 0 after the last beat.
  - With `PKT_LEN`=1, `m_last` equals `m_valid`.
- Reset mid-operation:
  - Buffer contents, `inflight` and `beat_cnt` are discarded.
  - Data the FIFO returns in the cycle after reset is ignored.
  - The FIFO is expected to be reset in the same cycle.

## Timing
- Latency: `fifo_rd_en` high in cycle T gives data on `fifo_rd_data` in T+1, captured at the end of T+1, and `m_valid`=1 in T+2.
- Throughput: 1 word/cycle sustained with `m_ready`=1 and the FIFO non-empty.
- Restart after a stall: when `occ`=2, `inflight`=0 and `m_ready` rises in cycle T, a read issues in T because the `pop` credit is counted. The buffer refills without a bubble.
- Outputs `m_*` and `beat_cnt` are registered or register-derived. `fifo_rd_en` is the only combinational output.

## Structure
- Package `fifo_pkg`: `DATA_W` default, the `PKT_LEN` legality check, and the `occ_t` type (2-bit).
- Sub-module `fifo_stream_skid`: 2-entry buffer with capture/pop, occupancy and pointer wrap.
- Top level holds the credit logic and the beat counter.

## Test plan
- Single word: reset, FIFO holds 0xA5, `m_ready`=1. Expect `fifo_rd_en` pulses once, `m_valid`=1 two cycles later with `m_data`=0xA5, then `m_valid`=0.
- Streaming: 16 words 0x00..0x0F, `m_ready`=1, `PKT_LEN`=4. Expect one word per cycle, in order, and `m_last` on 0x03, 0x07, 0x0B, 0x0F.
- Backpressure: `m_ready`=0 for 10 cycles with the FIFO full. Expect at most 2 reads, `m_data` stable, no loss. On release, all 16 words arrive in order with no bubble.
- `en` toggle: `en` drops while a read is in flight. Expect that word delivered and no further `fifo_rd_en` until `en`=1.
- Reset mid-packet: assert `rst` with `occ`=2 and `beat_cnt`=2. Expect all outputs 0 the next cycle. The first word after reset carries `beat_cnt`=0.
